gamma_lut_pipe: RTL
===================

Name: gamma_lut_pipe

Overview:
Programmable, pipelined per-channel gamma correction for the HDMI video path. It replaces the fixed combinational gamma table. Each of CH_NUM colour channels indexes its own 2^DATA_W-entry RAM table. Tables are rewritable at runtime through a simple write port, and after reset they self-initialise to identity. Video sync/DE is delay-matched through the pipeline, and a bypass mode passes pixels through with the same latency.

Parameters:
DATA_W, 8, bits per colour channel; table depth = 2^DATA_W, entry width = DATA_W
CH_NUM, 3, number of colour channels (one table each)
CH_SEL_W, 2, width of table-select field; must satisfy 2^CH_SEL_W >= CH_NUM

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
bypass  input  1  1 = output equals delayed input; 0 = gamma-corrected output
vs_i  input  1  vertical sync in
hs_i  input  1  horizontal sync in
de_i  input  1  data enable in
pix_i  input  CH_NUM*DATA_W  packed pixel; channel k = bits [k*DATA_W +: DATA_W]
vs_o  input→output  1  vs_i delayed 2 cycles
hs_o  output  1  hs_i delayed 2 cycles
de_o  output  1  de_i delayed 2 cycles
pix_o  output  CH_NUM*DATA_W  corrected or bypassed pixel, same packing
wr_en  input  1  table write strobe (single cycle per entry)
wr_ch  input  CH_SEL_W  target channel table
wr_addr  input  DATA_W  table index
wr_data  input  DATA_W  table entry value
wr_ready  output  1  1 when writes are accepted
init_done  output  1  1 once identity initialisation has completed

(Note: vs_o is an output; the direction is "output".)

Behaviour:
- Reset (rst_n low, asynchronous): vs_o, hs_o, de_o, pix_o = 0; wr_ready = 0; init_done = 0; FSM = INIT; init counter = 0. Table RAM contents are not reset.
- FSM INIT:
  - Each cycle writes entry[cnt] = cnt into all CH_NUM tables simultaneously; cnt increments.
  - When cnt = 2^DATA_W-1 is written, the FSM goes to RUN on the next edge. INIT lasts exactly 2^DATA_W cycles.
  - wr_ready = 0 during INIT; wr_en is ignored (no queueing).
  - Video output is forced to the bypass path during INIT regardless of the bypass input.
- FSM RUN:
  - init_done = 1 and wr_ready = 1, both registered, asserting in the first RUN cycle.
  - Stays in RUN until reset.
- Table write in RUN: on wr_en = 1, entry[wr_addr] of table wr_ch is written with wr_data at that edge. A wr_ch >= CH_NUM write is ignored.
- Pipeline, fixed latency 2 cycles for all paths:
  - Stage 1: registered RAM read, address = pix_i channel k. Sync/DE, raw pixel and effective bypass are registered alongside.
  - Stage 2: select RAM data or raw pixel; output register.
- Latency: a pixel presented at edge N appears on pix_o after edge N+2. Sync/DE are aligned with it identically.
- Bypass is sampled with the pixel at stage 1, so a bypass toggle takes effect on a pixel boundary with no glitching mid-pixel.
- Read/write collision (same table, same address, same edge): the read returns the old entry (read-first). The new value is visible to pixels sampled from the next edge.
- Lookup is applied regardless of de_i; blanking pixels are passed through the table too.
- Reset mid-operation: everything returns to the reset state and re-initialises. A table loaded before reset is overwritten by identity.
- No arithmetic beyond counter increment; the counter is DATA_W+1 bits wide to detect the terminal count without wrap ambiguity.

Test Plan:
- Release reset, DATA_W=8: init_done rises exactly 256 cycles after the first post-reset edge (±1 register stage), and wr_ready follows the same timing. Afterwards pix_i=0x10_80_FF gives pix_o=0x10_80_FF two cycles later (identity).
- Latency/sync: drive de_i/hs_i/vs_i pattern 1,0,1,1 with a ramping pixel, bypass=0 → outputs are delayed exactly 2 cycles and pixel/sync stay aligned.
- Load table: write ch0 entry[1]=128 and ch2 entry[255]=0; then pix_i={ch2=255, ch1=1, ch0=1} → pix_o={0, 1, 128}. Channel 1 is unaffected.
- Bypass: same loaded table, bypass=1 → pix_o equals pix_i delayed 2. Toggling bypass on alternate pixels alternates corrected and raw output per pixel.
- Collision: in the same cycle, write ch0 entry[5]=200 and present ch0=5 → that pixel outputs the old value 5; the next pixel with ch0=5 outputs 200. A wr_ch=3 write with CH_NUM=3 changes nothing.
- Reset mid-RUN: assert rst_n low for 3 cycles after loading tables → outputs go 0 immediately (async) and wr_en is ignored until init_done. After INIT, ch0 entry[1] reads back as 1.

Source files
------------

// File: rtl/gamma_lut_pipe.sv
// gamma_lut_pipe: programmable per-channel gamma correction for the video path.
// Each colour channel owns a 2^DATA_W-entry table held in inferred block RAM.
// After reset the tables self-load with identity values; then a write port
// lets software rewrite entries at runtime. Video (pixel, sync, DE) passes
// through a fixed two-register pipeline; bypass uses the same latency.
module gamma_lut_pipe #(
   parameter int DATA_W   = 8,
   parameter int CH_NUM   = 3,
   parameter int CH_SEL_W = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bypass,
   input  logic                       vs_i,
   input  logic                       hs_i,
   input  logic                       de_i,
   input  logic [CH_NUM*DATA_W-1:0]   pix_i,
   output logic                       vs_o,
   output logic                       hs_o,
   output logic                       de_o,
   output logic [CH_NUM*DATA_W-1:0]   pix_o,
   input  logic                       wr_en,
   input  logic [CH_SEL_W-1:0]        wr_ch,
   input  logic [DATA_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   output logic                       init_done
);

   localparam int DEPTH = 1 << DATA_W;
   localparam int PIX_W = CH_NUM * DATA_W;
   // Terminal count of the identity fill; the counter carries one spare bit
   // so the last index never aliases with a wrapped value.
   localparam logic [DATA_W:0] CNT_LAST = (DATA_W + 1)'(DEPTH - 1);
   localparam logic [DATA_W:0] CNT_ONE  = (DATA_W + 1)'(1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [DATA_W:0]   cnt_reg, cnt_next;
   logic              init_done_reg, init_done_next;
   logic              wr_ready_reg, wr_ready_next;

   // Stage 1 registers travelling alongside the RAM read
   logic              vs_s1_reg, hs_s1_reg, de_s1_reg;
   logic [PIX_W-1:0]  pix_s1_reg;
   logic              byp_s1_reg;

   // Stage 2 (output) registers
   logic              vs_s2_reg, hs_s2_reg, de_s2_reg;
   logic [PIX_W-1:0]  pix_s2_reg;

   // Per-channel selection between table output and raw pixel
   logic [PIX_W-1:0]  pix_sel;

   // Control state, fill counter and the registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_INIT;
         cnt_reg       <= '0;
         init_done_reg <= 1'b0;
         wr_ready_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         init_done_reg <= init_done_next;
         wr_ready_reg  <= wr_ready_next;
      end
   end

   // Next-state logic: walk the fill counter once, then park in RUN
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      init_done_next = init_done_reg;
      wr_ready_next  = wr_ready_reg;
      case (state_reg)
         ST_INIT: begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_reg == CNT_LAST) begin
               state_next     = ST_RUN;
               init_done_next = 1'b1;
               wr_ready_next  = 1'b1;
            end
         end
         ST_RUN: begin
            init_done_next = 1'b1;
            wr_ready_next  = 1'b1;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         logic [DATA_W-1:0] tbl_mem [DEPTH];
         logic              tbl_we;
         logic [DATA_W-1:0] tbl_wa;
         logic [DATA_W-1:0] tbl_wd;
         logic [DATA_W-1:0] rd_data_reg;

         // Write port source: identity fill during INIT, host writes in RUN
         always_comb begin
            tbl_we = 1'b0;
            tbl_wa = wr_addr;
            tbl_wd = wr_data;
            if (state_reg == ST_INIT) begin
               tbl_we = 1'b1;
               tbl_wa = cnt_reg[DATA_W-1:0];
               tbl_wd = cnt_reg[DATA_W-1:0];
            end else begin
               tbl_we = wr_en && (wr_ch == CH_SEL_W'(gi));
            end
         end

         // Table RAM: read-first, registered read addressed by this channel
         always_ff @(posedge clk) begin
            if (tbl_we) begin
               tbl_mem[tbl_wa] <= tbl_wd;
            end
            rd_data_reg <= tbl_mem[pix_i[gi*DATA_W +: DATA_W]];
         end

         assign pix_sel[gi*DATA_W +: DATA_W] =
            byp_s1_reg ? pix_s1_reg[gi*DATA_W +: DATA_W] : rd_data_reg;
      end
   endgenerate

   // Stage 1: capture sync, raw pixel and the effective bypass per pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1_reg  <= 1'b0;
         hs_s1_reg  <= 1'b0;
         de_s1_reg  <= 1'b0;
         pix_s1_reg <= '0;
         byp_s1_reg <= 1'b1;
      end else begin
         vs_s1_reg  <= vs_i;
         hs_s1_reg  <= hs_i;
         de_s1_reg  <= de_i;
         pix_s1_reg <= pix_i;
         byp_s1_reg <= bypass || (state_reg != ST_RUN);
      end
   end

   // Stage 2: output register for the selected pixel and delayed sync
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s2_reg  <= 1'b0;
         hs_s2_reg  <= 1'b0;
         de_s2_reg  <= 1'b0;
         pix_s2_reg <= '0;
      end else begin
         vs_s2_reg  <= vs_s1_reg;
         hs_s2_reg  <= hs_s1_reg;
         de_s2_reg  <= de_s1_reg;
         pix_s2_reg <= pix_sel;
      end
   end

   assign vs_o      = vs_s2_reg;
   assign hs_o      = hs_s2_reg;
   assign de_o      = de_s2_reg;
   assign pix_o     = pix_s2_reg;
   assign wr_ready  = wr_ready_reg;
   assign init_done = init_done_reg;

endmodule
